multi_btn_fltr: RTL and testbench
=================================

MULTI_BTN_FLTR -- requirements
Module: multi_btn_fltr

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter CNTR_WIDTH, default 3: filter counter width; a level change is accepted after 2**CNTR_WIDTH consecutive CE ticks.
REQ-003 Parameter HOLD_WIDTH, default 8: hold counter width.
REQ-004 Parameter LONG_CNT, default 20: CE ticks of stable press before the first BTN_REPEAT pulse; 1 <= LONG_CNT < 2**HOLD_WIDTH.
REQ-005 Parameter REP_CNT, default 5: CE ticks between later BTN_REPEAT pulses; 1 <= REP_CNT <= LONG_CNT.
REQ-006 Parameter REPEAT_EN, default 1: 1 = auto-repeat; 0 = single long-press pulse only.
REQ-007 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-008 RST  input  1  reset, synchronous and active-high.
REQ-009 CE  input  1  sampling tick that advances the filter and hold counters.
REQ-010 BTN_IN  input  N_CH  raw asynchronous button levels, active-high.
REQ-011 BTN_STATE  output  N_CH  debounced level, registered.
REQ-012 BTN_PRESS  output  N_CH  one-cycle pulse on each accepted 0->1 transition.
REQ-013 BTN_RELEASE  output  N_CH  one-cycle pulse on each accepted 1->0 transition.
REQ-014 BTN_REPEAT  output  N_CH  one-cycle long-press or auto-repeat pulse.
REQ-015 BTN_ANY  output  1  registered OR of the BTN_PRESS inputs to the output register, aligned with BTN_PRESS.

Function
REQ-016 Each channel SHALL pass BTN_IN[i] through a two-flop synchronizer (d, s1) before any other logic uses it.
REQ-017 Filter rule: if s1 == stable, cnt <= 0 regardless of CE; else, if CE and cnt is all-ones, stable <= s1 and cnt <= 0; else, if CE, cnt <= cnt + 1.
REQ-018 Latency with CE held high: BTN_STATE[i] SHALL update on the (2**CNTR_WIDTH + 1)th rising edge after the edge that first samples the new level into d; 9 edges for CNTR_WIDTH=3.
REQ-019 BTN_PRESS[i] and BTN_RELEASE[i] SHALL be high exactly in the cycle in which BTN_STATE[i] first shows the new value; never both high at once.
REQ-020 Hold counter: held at 0 whenever stable == 0 or on the press-accept edge; increments once per CE tick while stable == 1.
REQ-021 When CE, stable == 1, no release is being accepted, and hold_cnt == LONG_CNT-1: BTN_REPEAT[i] <= 1.
REQ-022 On that BTN_REPEAT event, hold_cnt <= LONG_CNT-REP_CNT when REPEAT_EN = 1, giving one pulse every REP_CNT ticks after that. When REPEAT_EN = 0, hold_cnt <= LONG_CNT and saturates, with no further pulses until release.
REQ-023 If release acceptance and a repeat condition occur on the same edge, release SHALL win: BTN_RELEASE = 1 and BTN_REPEAT = 0.
REQ-024 A glitch shorter than 2**CNTR_WIDTH CE ticks SHALL produce no output change, and SHALL restart the count from 0.
REQ-025 Channels SHALL be fully independent; activity on one channel has no effect on any other.

Reset
REQ-026 While RST = 1 on a rising edge, every register SHALL be set to 0: synchronizers, cnt, stable, hold_cnt and all outputs.
REQ-027 Reset mid-operation SHALL abort any pending transition. A button held through reset release SHALL produce BTN_PRESS after the normal REQ-018 latency, counted from the first post-reset sampling edge.

Structure
REQ-028 Shared package btn_fltr_pkg SHALL hold the default parameter constants and the widths used by the bench.
REQ-029 Per-channel logic SHALL be a sub-module btn_fltr_ch, instantiated N_CH times by a generate loop; the top adds only BTN_ANY.

Verification
REQ-030 Setup: N_CH=4, CNTR_WIDTH=3, CE=1 every cycle, LONG_CNT=20, REP_CNT=5. Clean press on channel 0 -> BTN_STATE[0] and BTN_PRESS[0] high 9 edges after sampling; BTN_ANY high in the same cycle.
REQ-031 Same setup, 5-cycle glitch on channel 1 -> no output change on any channel.
REQ-032 Same setup, channel 2 held for 40 cycles after the press -> BTN_REPEAT[2] at 20, 25, 30 and 35 cycles after BTN_PRESS[2]. With REPEAT_EN=0 -> single pulse at 20 only.
REQ-033 Release timed to coincide with a repeat slot -> BTN_RELEASE = 1, BTN_REPEAT = 0.
REQ-034 RST pulsed mid-filter while channel 3 is held -> all outputs 0; BTN_PRESS[3] 9 edges after the first post-reset sampling edge.
REQ-035 CE = 1 every 4th cycle -> acceptance takes 8 CE ticks; counters frozen between ticks.

Source files
------------

// File: rtl/btn_fltr_pkg.sv
// Shared defaults for the multi-channel button filter and the widths the
// bench builds its stimulus and reference model from.
// No ports: package only.
package btn_fltr_pkg;

  localparam int unsigned BTN_N_CH       = 4;
  localparam int unsigned BTN_CNTR_WIDTH = 3;
  localparam int unsigned BTN_HOLD_WIDTH = 8;
  localparam int unsigned BTN_LONG_CNT   = 20;
  localparam int unsigned BTN_REP_CNT    = 5;
  localparam int unsigned BTN_REPEAT_EN  = 1;

  typedef logic [BTN_N_CH-1:0] btn_vec_t;

endpackage

// File: rtl/multi_btn_fltr_if.sv
// Bundle of the sampling tick, raw button levels and all filtered outputs.
//   CE          tick that advances filter and hold counters
//   BTN_IN      raw asynchronous button levels, active-high
//   BTN_STATE   debounced level
//   BTN_PRESS   one-cycle pulse per accepted 0->1
//   BTN_RELEASE one-cycle pulse per accepted 1->0
//   BTN_REPEAT  one-cycle long-press / auto-repeat pulse
//   BTN_ANY     OR of BTN_PRESS, aligned with it
// master: drives CE/BTN_IN; slave: the filter.
interface multi_btn_fltr_if
  import btn_fltr_pkg::*;
#(
  parameter int unsigned N_CH = BTN_N_CH
) ();

  logic            CE;
  logic [N_CH-1:0] BTN_IN;
  logic [N_CH-1:0] BTN_STATE;
  logic [N_CH-1:0] BTN_PRESS;
  logic [N_CH-1:0] BTN_RELEASE;
  logic [N_CH-1:0] BTN_REPEAT;
  logic            BTN_ANY;

  modport master (
    output CE, BTN_IN,
    input  BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_REPEAT, BTN_ANY
  );

  modport slave (
    input  CE, BTN_IN,
    output BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_REPEAT, BTN_ANY
  );

endinterface

// File: rtl/btn_fltr_ch.sv
// One button channel: two-flop synchronizer, CE-driven debounce counter,
// press/release pulses and a hold counter producing long-press/auto-repeat.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_ce          sampling tick
//   i_btn         raw button level
//   o_state       debounced level
//   o_press       pulse on accepted 0->1
//   o_release     pulse on accepted 1->0
//   o_repeat      long-press / auto-repeat pulse
//   o_press_nxt   D input of the press register (for the top's BTN_ANY)
module btn_fltr_ch #(
  parameter int unsigned CNTR_WIDTH = 3,
  parameter int unsigned HOLD_WIDTH = 8,
  parameter int unsigned LONG_CNT   = 20,
  parameter int unsigned REP_CNT    = 5,
  parameter int unsigned REPEAT_EN  = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ce,
  input  logic i_btn,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_press_nxt
);

  localparam logic [HOLD_WIDTH-1:0] LP_HOLD_LAST = HOLD_WIDTH'(LONG_CNT - 1);
  localparam logic [HOLD_WIDTH-1:0] LP_HOLD_SAT  = HOLD_WIDTH'(LONG_CNT);
  // Auto-repeat rewinds the counter so it reaches LAST again after REP_CNT
  // ticks; single-shot parks it one past LAST where it can never match.
  localparam logic [HOLD_WIDTH-1:0] LP_HOLD_RELOAD =
    (REPEAT_EN != 0) ? HOLD_WIDTH'(LONG_CNT - REP_CNT) : LP_HOLD_SAT;

  logic                  r_d, r_s1, r_stable;
  logic                  r_press, r_release, r_repeat;
  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [HOLD_WIDTH-1:0] r_hold;

  logic w_differ, w_accept, w_rep_hit;

  assign w_differ  = (r_s1 != r_stable);
  assign w_accept  = i_ce & w_differ & (r_cnt == '1);
  // While stable is high, an accept can only be a release; release wins.
  assign w_rep_hit = i_ce & r_stable & ~w_accept & (r_hold == LP_HOLD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d       <= 1'b0;
      r_s1      <= 1'b0;
      r_stable  <= 1'b0;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_d  <= i_btn;
      r_s1 <= r_d;

      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_s1;
        r_cnt    <= '0;
      end else if (i_ce) begin
        r_cnt <= r_cnt + CNTR_WIDTH'(1);
      end

      if (!r_stable || w_accept) begin
        r_hold <= '0;
      end else if (i_ce) begin
        if (r_hold == LP_HOLD_LAST) begin
          r_hold <= LP_HOLD_RELOAD;
        end else if (r_hold != LP_HOLD_SAT) begin
          r_hold <= r_hold + HOLD_WIDTH'(1);
        end
      end

      r_press   <= w_accept & r_s1;
      r_release <= w_accept & ~r_s1;
      r_repeat  <= w_rep_hit;
    end
  end

  assign o_state     = r_stable;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_repeat    = r_repeat;
  assign o_press_nxt = w_accept & r_s1;

endmodule

// File: rtl/multi_btn_fltr.sv
// N_CH independent debounced button channels with press/release pulses,
// long-press / auto-repeat, and a combined BTN_ANY press indicator.
//   CLK  sole clock
//   RST  synchronous active-high reset
//   bus  multi_btn_fltr_if slave: CE, BTN_IN in; filtered outputs out
module multi_btn_fltr
  import btn_fltr_pkg::*;
#(
  parameter int unsigned N_CH       = BTN_N_CH,
  parameter int unsigned CNTR_WIDTH = BTN_CNTR_WIDTH,
  parameter int unsigned HOLD_WIDTH = BTN_HOLD_WIDTH,
  parameter int unsigned LONG_CNT   = BTN_LONG_CNT,
  parameter int unsigned REP_CNT    = BTN_REP_CNT,
  parameter int unsigned REPEAT_EN  = BTN_REPEAT_EN
) (
  input  logic             CLK,
  input  logic             RST,
  multi_btn_fltr_if.slave  bus
);

  logic [N_CH-1:0] w_state, w_press, w_release, w_repeat, w_press_nxt;
  logic            r_any;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_fltr_ch #(
      .CNTR_WIDTH (CNTR_WIDTH),
      .HOLD_WIDTH (HOLD_WIDTH),
      .LONG_CNT   (LONG_CNT),
      .REP_CNT    (REP_CNT),
      .REPEAT_EN  (REPEAT_EN)
    ) u_ch (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_ce        (bus.CE),
      .i_btn       (bus.BTN_IN[g]),
      .o_state     (w_state[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g]),
      .o_repeat    (w_repeat[g]),
      .o_press_nxt (w_press_nxt[g])
    );
  end

  // Registered from the press registers' D inputs so it lines up with BTN_PRESS.
  always_ff @(posedge CLK) begin
    if (RST) r_any <= 1'b0;
    else     r_any <= |w_press_nxt;
  end

  assign bus.BTN_STATE   = w_state;
  assign bus.BTN_PRESS   = w_press;
  assign bus.BTN_RELEASE = w_release;
  assign bus.BTN_REPEAT  = w_repeat;
  assign bus.BTN_ANY     = r_any;

endmodule

// File: tb/tb_multi_btn_fltr.sv
// Bench for multi_btn_fltr: directed scenarios followed by random traffic,
// every cycle compared against a reference model of the filtering rules.
// Two DUTs share stimulus: dut_a auto-repeats, dut_b is single-shot.
module tb_multi_btn_fltr;
  import btn_fltr_pkg::*;

  localparam int unsigned N    = BTN_N_CH;
  localparam int unsigned CW   = BTN_CNTR_WIDTH;
  localparam int          LONG = BTN_LONG_CNT;
  localparam int          REP  = BTN_REP_CNT;
  localparam int          ACC  = 1 << CW;   // CE ticks to accept a level
  localparam int          LAT  = ACC + 1;   // edges from d-sample to state

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ce  = 1'b1;
  logic [N-1:0] btn = '0;

  int n_tests = 0;
  int n_fail  = 0;

  multi_btn_fltr_if #(.N_CH(N)) bus_a ();
  multi_btn_fltr_if #(.N_CH(N)) bus_b ();

  assign bus_a.CE = ce;
  assign bus_a.BTN_IN = btn;
  assign bus_b.CE = ce;
  assign bus_b.BTN_IN = btn;

  multi_btn_fltr #(
    .N_CH(N), .CNTR_WIDTH(CW), .HOLD_WIDTH(BTN_HOLD_WIDTH),
    .LONG_CNT(LONG), .REP_CNT(REP), .REPEAT_EN(1)
  ) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));

  multi_btn_fltr #(
    .N_CH(N), .CNTR_WIDTH(CW), .HOLD_WIDTH(BTN_HOLD_WIDTH),
    .LONG_CNT(LONG), .REP_CNT(REP), .REPEAT_EN(0)
  ) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  always #5 clk = ~clk;

  // Reference model: delayed copies of the input, a count of consecutive
  // disagreeing CE ticks, and CE ticks elapsed since the press.
  logic [N-1:0] m_d = '0, m_s1 = '0, m_stable = '0;
  int           m_diff [N];
  int           m_held [N];
  logic [N-1:0] e_state = '0, e_press = '0, e_rel = '0, e_rep_a = '0, e_rep_b = '0;
  logic         e_any = 1'b0;

  task automatic model();
    logic [N-1:0] p, r, ra, rb;
    p = '0; r = '0; ra = '0; rb = '0;
    if (rst) begin
      m_d = '0; m_s1 = '0; m_stable = '0;
      for (int i = 0; i < N; i++) begin m_diff[i] = 0; m_held[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_s1[i] != m_stable[i]) begin
          if (ce) begin
            m_diff[i]++;
            if (m_diff[i] == ACC) begin
              m_diff[i] = 0;
              m_stable[i] = m_s1[i];
              if (m_s1[i]) begin p[i] = 1'b1; m_held[i] = 0; end
              else r[i] = 1'b1;
            end
          end
        end else begin
          m_diff[i] = 0;
        end
        if (!p[i] && !r[i] && m_stable[i] && ce) begin
          m_held[i]++;
          if (m_held[i] == LONG) begin
            ra[i] = 1'b1; rb[i] = 1'b1;
          end else if (m_held[i] > LONG && ((m_held[i] - LONG) % REP) == 0) begin
            ra[i] = 1'b1;
          end
        end
      end
      m_s1 = m_d;
      m_d  = btn;
    end
    e_state = m_stable; e_press = p; e_rel = r;
    e_rep_a = ra; e_rep_b = rb; e_any = |p;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_state",   32'(bus_a.BTN_STATE),   32'(e_state));
    chk("a_press",   32'(bus_a.BTN_PRESS),   32'(e_press));
    chk("a_release", 32'(bus_a.BTN_RELEASE), 32'(e_rel));
    chk("a_repeat",  32'(bus_a.BTN_REPEAT),  32'(e_rep_a));
    chk("a_any",     32'(bus_a.BTN_ANY),     32'(e_any));
    chk("b_state",   32'(bus_b.BTN_STATE),   32'(e_state));
    chk("b_press",   32'(bus_b.BTN_PRESS),   32'(e_press));
    chk("b_release", 32'(bus_b.BTN_RELEASE), 32'(e_rel));
    chk("b_repeat",  32'(bus_b.BTN_REPEAT),  32'(e_rep_b));
    chk("b_any",     32'(bus_b.BTN_ANY),     32'(e_any));
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  initial begin
    int found, anyv, chg, na, nb, ticks, k;
    int ra [4];
    int rb [4];

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_state", 32'(bus_a.BTN_STATE | bus_b.BTN_STATE), 32'd0);
    chk("rst_pulses", 32'(bus_a.BTN_PRESS | bus_a.BTN_RELEASE | bus_a.BTN_REPEAT), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Clean press on channel 0: first step after setting btn is the d-sample edge
    btn[0] = 1'b1; found = 0; anyv = 0;
    for (int i = 1; i <= LAT + 3; i++) begin
      step();
      if (bus_a.BTN_PRESS[0] && found == 0) begin found = i; anyv = int'(bus_a.BTN_ANY); end
    end
    chk("press0_latency", 32'(found), 32'(LAT + 1));
    chk("press0_any", 32'(anyv), 32'd1);
    chk("press0_state", 32'(bus_a.BTN_STATE[0]), 32'd1);
    btn[0] = 1'b0;
    repeat (LAT + 3) step();

    // 5-cycle glitch on channel 1: nothing may move anywhere
    chg = 0;
    btn[1] = 1'b1;
    for (int i = 0; i < 5 + LAT + 5; i++) begin
      if (i == 5) btn[1] = 1'b0;
      step();
      if ((bus_a.BTN_STATE | bus_a.BTN_PRESS | bus_a.BTN_RELEASE | bus_a.BTN_REPEAT) != 0
          || bus_a.BTN_ANY) chg++;
    end
    chk("glitch_quiet", 32'(chg), 32'd0);

    // Long hold on channel 2: repeat offsets relative to the press pulse
    btn[2] = 1'b1;
    k = 0;
    while (k < 3 * LAT && !bus_a.BTN_PRESS[2]) begin step(); k++; end
    chk("press2_seen", 32'(bus_a.BTN_PRESS[2]), 32'd1);
    na = 0; nb = 0;
    for (int i = 0; i < 4; i++) begin ra[i] = -1; rb[i] = -1; end
    for (int off = 1; off <= 38; off++) begin
      step();
      if (bus_a.BTN_REPEAT[2]) begin if (na < 4) ra[na] = off; na++; end
      if (bus_b.BTN_REPEAT[2]) begin if (nb < 4) rb[nb] = off; nb++; end
    end
    chk("rep_a_count", 32'(na), 32'd4);
    for (int i = 0; i < 4; i++) chk("rep_a_offset", 32'(ra[i]), 32'(LONG + i * REP));
    chk("rep_b_count", 32'(nb), 32'd1);
    chk("rep_b_offset", 32'(rb[0]), 32'(LONG));
    btn[2] = 1'b0;
    repeat (LAT + 3) step();

    // Release accepted exactly on the first repeat slot: release wins on both DUTs
    btn[2] = 1'b1;
    k = 0;
    while (k < 3 * LAT && !bus_a.BTN_PRESS[2]) begin step(); k++; end
    chk("press2b_seen", 32'(bus_a.BTN_PRESS[2]), 32'd1);
    for (int off = 1; off <= LONG - LAT - 1; off++) step();
    btn[2] = 1'b0;
    for (int off = LONG - LAT; off <= LONG; off++) step();
    chk("coinc_rel_a", 32'(bus_a.BTN_RELEASE[2]), 32'd1);
    chk("coinc_rep_a", 32'(bus_a.BTN_REPEAT[2]), 32'd0);
    chk("coinc_rel_b", 32'(bus_b.BTN_RELEASE[2]), 32'd1);
    chk("coinc_rep_b", 32'(bus_b.BTN_REPEAT[2]), 32'd0);
    repeat (3) step();

    // Reset mid-filter with channel 3 held through it
    btn[3] = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    repeat (2) step();
    chk("rst_mid_outs", 32'(bus_a.BTN_STATE | bus_a.BTN_PRESS | bus_a.BTN_RELEASE
                         | bus_a.BTN_REPEAT | bus_b.BTN_STATE), 32'd0);
    chk("rst_mid_any", 32'(bus_a.BTN_ANY | bus_b.BTN_ANY), 32'd0);
    rst = 1'b0;
    found = 0;
    for (int i = 1; i <= LAT + 3; i++) begin
      step();
      if (bus_a.BTN_PRESS[3] && found == 0) found = i;
    end
    chk("press3_latency", 32'(found), 32'(LAT + 1));
    btn[3] = 1'b0;
    repeat (LAT + 3) step();

    // CE every 4th cycle: count ticks from the edge s1 first differs to the press
    btn[1] = 1'b1; ticks = 0; found = 0;
    for (int i = 1; i <= 60 && found == 0; i++) begin
      ce = ((i % 4) == 1);
      step();
      if (i >= 3 && ce) ticks++;
      if (bus_a.BTN_PRESS[1]) found = i;
    end
    chk("ce4_seen", 32'(found != 0), 32'd1);
    chk("ce4_ticks", 32'(ticks), 32'(ACC));
    ce = 1'b1;
    btn[1] = 1'b0;
    repeat (LAT + 3) step();

    // Random traffic: slower-toggling channels reach long-press territory
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, (8 << i) - 1) == 0) btn[i] = ~btn[i];
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
